// File: rtl/cryo_freq_meter.sv
// cryo_freq_meter: multi-channel rising-edge counter / frequency meter.
// Each asynchronous input is synchronised and edge-detected continuously.
// A start request opens a gate window of gate_len clk cycles. During the
// window, rising edges are counted per channel with saturation and a sticky
// overflow flag. Results are read back one byte at a time through rd_data.
//
// Handshake: start is a level sampled on every clk edge. It is accepted only
// in IDLE or DONE. While the window is open (busy=1), start is ignored.
// done stays high with results held until the next accepted start.
module cryo_freq_meter #(
  parameter int NCH  = 4,
  parameter int CW   = 16,
  parameter int GW   = 16,
  parameter int SYNC = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [GW-1:0]                            gate_len,
  input  logic [NCH-1:0]                           sig_in,
  input  logic [$clog2(NCH)-1:0]                   sel_ch,
  input  logic [((CW/8) > 1 ? $clog2(CW/8) : 1)-1:0] sel_byte,
  output logic                                     busy,
  output logic                                     done,
  output logic [NCH-1:0]                           overflow,
  output logic [7:0]                               rd_data
);

  localparam int NB  = CW / 8;
  localparam int SCW = $clog2(NCH);
  localparam int SBW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Synchroniser chain: index 0 is the first (metastable-facing) stage.
  logic [SYNC-1:0][NCH-1:0] sync_q, sync_d;
  logic [NCH-1:0]           prev_q, prev_d;
  logic [NCH-1:0]           edge_pulse;

  state_t                   state_q, state_d;
  logic [GW-1:0]            gcnt_q, gcnt_d;
  logic [CW-1:0]            count_q [NCH];
  logic [CW-1:0]            count_d [NCH];
  logic [NCH-1:0]           ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Input path next values and edge detection, independent of FSM state.
  always_comb begin
    sync_d     = {sync_q[SYNC-2:0], sig_in};
    prev_d     = sync_q[SYNC-1];
    edge_pulse = sync_q[SYNC-1] & ~prev_q;
  end

  // Synchroniser and previous-value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Next-state logic: start acceptance, gate countdown, saturating counts.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          for (int i = 0; i < NCH; i++) count_d[i] = '0;
          ovf_d   = '0;
          gcnt_d  = gate_len;
          state_d = (gate_len != '0) ? S_COUNT : S_DONE;
        end
      end
      S_COUNT: begin
        gcnt_d = gcnt_q - 1'b1;
        // Exit on 1 rather than 0 so the window is exactly gate_len cycles.
        if (gcnt_q == GW'(1)) state_d = S_DONE;
        for (int i = 0; i < NCH; i++) begin
          if (edge_pulse[i]) begin
            if (count_q[i] != {CW{1'b1}}) count_d[i] = count_q[i] + 1'b1;
            else                          ovf_d[i]   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_COUNT);
    done_d = (state_d == S_DONE);
  end

  // FSM state, gate counter, counts, flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gcnt_q  <= '0;
      for (int i = 0; i < NCH; i++) count_q[i] <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      for (int i = 0; i < NCH; i++) count_q[i] <= count_d[i];
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Byte readback mux; unmatched channel/byte selects read as zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_ch == SCW'(i) && sel_byte == SBW'(b)) rd_data = count_q[i][b*8 +: 8];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: doc/cryo_freq_meter.md
Name: cryo_freq_meter

Overview:
- Parametrised multi-channel edge counter / frequency meter for cryogenic characterisation of on-chip oscillators and test structures.
- Counts rising edges on NCH independent inputs during a programmable gate window.
- Results are read back byte-wise over the 8-bit user output bus of the top-level harness.
- Successor to the single-function user-project slot: channel count, counter width and gate length are generic.

Parameters:
- NCH, 4, number of measured channels (>=2).
- CW, 16, per-channel counter width in bits (multiple of 8, >=8).
- GW, 16, gate-length register width in bits.
- SYNC, 2, synchroniser depth per channel (>=2).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  measurement request, sampled high on a clk edge.
- gate_len  in  GW  gate window length in clk cycles; sampled when start is accepted.
- sig_in  in  NCH  asynchronous signals to measure.
- sel_ch  in  $clog2(NCH)  readback channel select.
- sel_byte  in  max(1,$clog2(CW/8))  readback byte select; 0 = LSB.
- busy  out  1  high while the gate window is open.
- done  out  1  high when results are valid and held.
- overflow  out  NCH  sticky per-channel saturation flag.
- rd_data  out  8  selected count byte.

Behaviour:
- Reset: asserting rst clears all state immediately and asynchronously, including synchronisers, edge registers, counts, gate counter, busy, done, overflow and state. State returns to IDLE. rd_data then reads 0x00.
- Input path:
  - Each sig_in bit passes a SYNC-flop synchroniser, then a previous-value register.
  - edge[i] = synced & ~prev. This path runs in every state.
  - A rising edge on sig_in produces its edge pulse SYNC+1 clk cycles later.
- FSM states: IDLE, COUNT, DONE. Encoding is free.
- Start acceptance (start=1 in IDLE or DONE):
  - Clear all counts and overflow.
  - Load gcnt = gate_len.
  - Next state is COUNT if gate_len != 0; otherwise DONE.
- COUNT:
  - Each cycle, for every channel with edge[i]=1: if count != all-ones, count increments; else count holds and overflow[i] sets.
  - gcnt decrements every cycle. When gcnt == 1 in COUNT, next state is DONE.
  - COUNT therefore lasts exactly gate_len cycles. Only edge pulses in those cycles are counted.
  - start is ignored in COUNT.
- DONE:
  - Counts and overflow hold.
  - A new start is accepted as described above, clearing counts the same cycle.
- Outputs:
  - busy = (state == COUNT), registered.
  - done = (state == DONE), registered.
  - With gate_len = 0, done rises the cycle after start and busy never asserts.
- Readback:
  - rd_data = byte sel_byte of count[sel_ch], combinational.
  - If sel_ch >= NCH or sel_byte >= CW/8, rd_data = 0x00.
  - Reads are legal in any state; in COUNT they show live values.
- Arithmetic: unsigned, saturating at 2^CW-1. gcnt is GW bits and never wraps, because the exit condition is gcnt == 1.

Test Plan:
- Reset: assert rst mid-operation with arbitrary inputs -> busy=0, done=0, overflow=0, rd_data=0x00 with no clk edge needed. After release, state is IDLE.
- Basic count (NCH=4, CW=16): ch0 is a clk/4 square wave running long before start; gate_len=100 -> busy high exactly 100 cycles, then done=1. sel_ch=0 reads byte0=0x19, byte1=0x00. Idle channels read 0.
- Multi-channel: ch1 clk/2, ch2 clk/8, gate_len=400 -> counts 200 (0xC8), 50 (0x32). ch3 held high reads 0. sel_ch=3 byte1 reads 0x00.
- Saturation (CW=8 instance): ch0 clk/2, gate_len=600 -> count0=0xFF, overflow[0]=1, other overflow bits 0. A new start clears overflow in the next cycle.
- Zero gate: gate_len=0, start pulse -> done=1 one cycle later, busy never high, all counts 0.
- Control corner cases:
  - start held high through COUNT -> no restart; window length unchanged.
  - start in DONE -> counts clear and COUNT re-enters.
  - Out-of-range sel_ch (NCH=3 instance, sel_ch=3) -> rd_data=0x00.
